// File: rtl/diff_maccum_accumulator_pkg.sv
// Shared encodings for the synapse weight-row stream and its consumers.
// Frame ctrl codes, spike tag codes, FSM states and the tag-width helper.
package diff_maccum_accumulator_pkg;

   localparam logic [1:0] CTRL_MID = 2'b00;
   localparam logic [1:0] CTRL_SOF = 2'b01;
   localparam logic [1:0] CTRL_EOF = 2'b10;
   localparam logic [1:0] CTRL_ONE = 2'b11;

   localparam logic [1:0] TAG_ADD = 2'b10;
   localparam logic [1:0] TAG_SUB = 2'b01;

   typedef enum logic {
      ST_ACC,
      ST_OUT
   } state_t;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_ADD,
      OP_SUB
   } lane_op_t;

   // "rc" streams carry a differential 2-bit tag, others a 1-bit enable
   function automatic int tag_width(input string kind);
      return (kind == "rc") ? 2 : 1;
   endfunction

endpackage

// File: rtl/diff_maccum_accumulator_if.sv
// Weight-row input stream and result output stream of the accumulator.
// master drives beats and result-ready; slave is the accumulator side.
interface diff_maccum_accumulator_if #(
   parameter int NB = 4,
   parameter int WD = 4,
   parameter int AW = 12,
   parameter int TW = 2
) ();

   logic                   iValid_AM;
   logic                   oReady_AM;
   logic [2+TW+NB*WD-1:0]  iData_AM;
   logic                   oValid_BM;
   logic                   iReady_BM;
   logic [NB*AW-1:0]       oData_BM;

   modport master (
      output iValid_AM,
      output iData_AM,
      output iReady_BM,
      input  oReady_AM,
      input  oValid_BM,
      input  oData_BM
   );

   modport slave (
      input  iValid_AM,
      input  iData_AM,
      input  iReady_BM,
      output oReady_AM,
      output oValid_BM,
      output oData_BM
   );

endinterface

// File: rtl/dma_sat_lane.sv
// One postsynaptic lane: AW-bit signed accumulator with optional clear,
// add/subtract of a sign-extended weight and saturation to the AW range.
module dma_sat_lane
   import diff_maccum_accumulator_pkg::*;
#(
   parameter int WD = 4,
   parameter int AW = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   input  lane_op_t             op,
   input  logic signed [WD-1:0] w,
   output logic signed [AW-1:0] acc
);

   logic signed [AW:0]   base;
   logic signed [AW:0]   wx;
   logic signed [AW:0]   sum;
   logic signed [AW-1:0] nxt;

   always_comb begin
      base = clr ? '0 : {acc[AW-1], acc};
      wx   = {{(AW+1-WD){w[WD-1]}}, w};
      unique case (op)
         OP_ADD:  sum = base + wx;
         OP_SUB:  sum = base - wx;
         default: sum = base;
      endcase
      // top two bits disagree only when the true sum left the AW range
      if (sum[AW] != sum[AW-1]) begin
         nxt = sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                       : {1'b0, {(AW-1){1'b1}}};
      end else begin
         nxt = sum[AW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= nxt;
      end
   end

endmodule

// File: rtl/diff_maccum_accumulator.sv
// Differential MAC over a weight-row stream: NB saturating lanes, one
// result beat per frame; the top holds the frame FSM and handshakes.
module diff_maccum_accumulator
   import diff_maccum_accumulator_pkg::*;
#(
   parameter int    NB   = 4,
   parameter int    WD   = 4,
   parameter int    AW   = 12,
   parameter string TYPE = "rc"
) (
   input  logic                      iCLK,
   input  logic                      iRST,
   diff_maccum_accumulator_if.slave  bus
);

   localparam int TW = tag_width(TYPE);
   localparam int DW = 2 + TW + NB*WD;

   state_t            st;
   state_t            st_nxt;
   logic              take;
   logic              clr;
   logic              last;
   logic [1:0]        ctrl;
   logic [TW-1:0]     tag;
   lane_op_t          op;
   logic signed [AW-1:0] acc [NB];

   assign ctrl = bus.iData_AM[DW-1 -: 2];
   assign tag  = bus.iData_AM[NB*WD +: TW];
   assign take = bus.iValid_AM & bus.oReady_AM;
   assign clr  = (ctrl == CTRL_SOF) || (ctrl == CTRL_ONE);
   assign last = (ctrl == CTRL_EOF) || (ctrl == CTRL_ONE);

   generate
      if (TW == 2) begin : g_rc
         always_comb begin
            op = OP_HOLD;
            unique case (1'b1)
               (tag == TAG_ADD): op = OP_ADD;
               (tag == TAG_SUB): op = OP_SUB;
               default:          op = OP_HOLD;
            endcase
         end
      end else begin : g_bin
         always_comb begin
            op = tag[0] ? OP_ADD : OP_HOLD;
         end
      end
   endgenerate

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         st <= ST_ACC;
      end else begin
         st <= st_nxt;
      end
   end

   always_comb begin
      st_nxt = st;
      unique case (st)
         ST_ACC: if (take && last) st_nxt = ST_OUT;
         ST_OUT: if (bus.iReady_BM) st_nxt = ST_ACC;
         default: st_nxt = ST_ACC;
      endcase
   end

   // lanes only update on accepted beats, so sums stay frozen in OUT
   always_comb begin
      bus.oReady_AM = (st == ST_ACC) && !iRST;
      bus.oValid_BM = (st == ST_OUT);
   end

   generate
      for (genvar i = 0; i < NB; i++) begin : g_lane
         dma_sat_lane #(
            .WD (WD),
            .AW (AW)
         ) u_lane (
            .clk (iCLK),
            .rst (iRST),
            .en  (take),
            .clr (clr),
            .op  (op),
            .w   (bus.iData_AM[i*WD +: WD]),
            .acc (acc[i])
         );
      end
   endgenerate

   always_comb begin
      bus.oData_BM = '0;
      for (int i = 0; i < NB; i++) begin
         bus.oData_BM[i*AW +: AW] = acc[i];
      end
   end

endmodule

// File: tb/tb_diff_maccum_accumulator.sv
// Directed bench for diff_maccum_accumulator (NB=4, WD=4, AW=12, rc).
// Expected sums are hand-computed per lane, listed lane3..lane0.
module tb_diff_maccum_accumulator;

   localparam logic [1:0] C_MID = 2'b00;
   localparam logic [1:0] C_SOF = 2'b01;
   localparam logic [1:0] C_EOF = 2'b10;
   localparam logic [1:0] C_ONE = 2'b11;
   localparam logic [1:0] T_ADD = 2'b10;
   localparam logic [1:0] T_SUB = 2'b01;

   logic iCLK;
   logic iRST;
   int   checks;
   int   errors;
   int   waits;

   diff_maccum_accumulator_if #(
      .NB (4), .WD (4), .AW (12), .TW (2)
   ) ifc ();

   diff_maccum_accumulator #(
      .NB (4), .WD (4), .AW (12), .TYPE ("rc")
   ) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (ifc)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   task automatic chk(input string tg, input logic [63:0] o,
                      input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tg, o, e);
      end
   endtask

   function automatic logic [47:0] p4(input int a3, input int a2,
                                      input int a1, input int a0);
      return {a3[11:0], a2[11:0], a1[11:0], a0[11:0]};
   endfunction

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   // offer one beat, hold it until accepted; waits = edges taken
   task automatic send(input logic [1:0] c, input logic [1:0] t,
                       input logic signed [3:0] w0,
                       input logic signed [3:0] w1,
                       input logic signed [3:0] w2,
                       input logic signed [3:0] w3);
      int   n;
      logic a;
      ifc.iData_AM  = {c, t, w3, w2, w1, w0};
      ifc.iValid_AM = 1'b1;
      n = 0;
      do begin
         a = ifc.oReady_AM;
         tick();
         n++;
      end while (!a && n < 50);
      if (!a) chk("accept_timeout", 64'(a), 64'd1);
      ifc.iValid_AM = 1'b0;
      waits = n;
      if (c[1]) chk("eof_latency", 64'(ifc.oValid_BM), 64'd1);
   endtask

   task automatic expect_out(input string tg, input logic [47:0] e);
      int n;
      n = 0;
      while (!ifc.oValid_BM && n < 20) begin
         tick();
         n++;
      end
      chk({tg, "_valid"}, 64'(ifc.oValid_BM), 64'd1);
      chk({tg, "_data"}, 64'(ifc.oData_BM), 64'(e));
      tick();
      chk({tg, "_drain"}, 64'(ifc.oValid_BM), 64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      waits  = 0;
      iRST = 1'b1;
      ifc.iValid_AM = 1'b0;
      ifc.iData_AM  = '0;
      ifc.iReady_BM = 1'b0;
      #1;
      chk("rst_ready", 64'(ifc.oReady_AM), 64'd0);
      tick();
      chk("rst_valid", 64'(ifc.oValid_BM), 64'd0);
      chk("rst_data", 64'(ifc.oData_BM), 64'd0);
      iRST = 1'b0;
      #1;
      chk("post_rst_ready", 64'(ifc.oReady_AM), 64'd1);

      // lane0 1-1-1=-1, lane1 2-1+0=1, lane2 3-1+0=2, lane3 4-1+7=10
      ifc.iReady_BM = 1'b1;
      send(C_SOF, T_ADD, 1, 2, 3, 4);
      send(C_MID, T_SUB, 1, 1, 1, 1);
      send(C_EOF, T_ADD, -1, 0, 0, 7);
      expect_out("frame1", p4(10, 2, 1, -1));

      // single beat: 0-(-8)=8; then tags 00/11 keep the retained sums
      send(C_ONE, T_SUB, -8, -8, -8, -8);
      expect_out("single", p4(8, 8, 8, 8));
      send(C_MID, 2'b00, 5, 5, 5, 5);
      send(C_EOF, 2'b11, 3, 3, 3, 3);
      expect_out("notag", p4(8, 8, 8, 8));

      // backpressure: result held, next beat stalled and not lost
      ifc.iReady_BM = 1'b0;
      send(C_ONE, T_ADD, 1, 1, 1, 1);
      ifc.iData_AM  = {C_SOF, T_ADD, 16'h3333};
      ifc.iValid_AM = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", 64'(ifc.oValid_BM), 64'd1);
         chk("hold_data", 64'(ifc.oData_BM), 64'(p4(1, 1, 1, 1)));
         chk("hold_ready", 64'(ifc.oReady_AM), 64'd0);
      end
      ifc.iReady_BM = 1'b1;
      tick();
      chk("rel_valid", 64'(ifc.oValid_BM), 64'd0);
      chk("rel_ready", 64'(ifc.oReady_AM), 64'd1);
      send(C_SOF, T_ADD, 3, 3, 3, 3);
      chk("rel_accept_wait", 64'(waits), 64'd1);
      send(C_EOF, 2'b00, 0, 0, 0, 0);
      expect_out("stalled", p4(3, 3, 3, 3));

      // 300*7=2100 clips to 2047; 2047-600*7 clips to -2048
      send(C_SOF, T_ADD, 7, 7, 7, 7);
      repeat (298) send(C_MID, T_ADD, 7, 7, 7, 7);
      send(C_EOF, T_ADD, 7, 7, 7, 7);
      expect_out("sat_pos", p4(2047, 2047, 2047, 2047));
      repeat (599) send(C_MID, T_SUB, 7, 7, 7, 7);
      send(C_EOF, T_SUB, 7, 7, 7, 7);
      expect_out("sat_neg", p4(-2048, -2048, -2048, -2048));

      // back-to-back single-beat frames, valid never dropped
      send(C_ONE, T_ADD, 1, 2, 3, 4);
      chk("b2b0_data", 64'(ifc.oData_BM), 64'(p4(4, 3, 2, 1)));
      send(C_ONE, T_SUB, 1, 1, 1, 1);
      chk("b2b1_wait", 64'(waits), 64'd2);
      chk("b2b1_data", 64'(ifc.oData_BM), 64'(p4(-1, -1, -1, -1)));
      send(C_ONE, T_ADD, -8, 7, 0, -1);
      chk("b2b2_wait", 64'(waits), 64'd2);
      chk("b2b2_data", 64'(ifc.oData_BM), 64'(p4(-1, 0, 7, -8)));
      tick();
      chk("b2b_drain", 64'(ifc.oValid_BM), 64'd0);

      // reset while a result is pending discards it
      ifc.iReady_BM = 1'b0;
      send(C_ONE, T_ADD, 5, 5, 5, 5);
      iRST = 1'b1;
      tick();
      iRST = 1'b0;
      #1;
      chk("rst_out_valid", 64'(ifc.oValid_BM), 64'd0);
      chk("rst_out_data", 64'(ifc.oData_BM), 64'd0);
      chk("rst_out_ready", 64'(ifc.oReady_AM), 64'd1);
      ifc.iReady_BM = 1'b1;
      send(C_EOF, T_ADD, 2, 3, 4, 5);
      expect_out("after_rst", p4(5, 4, 3, 2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
